// File: rtl/id_stage_sequencer.sv
// id_stage_sequencer: decode-stage controller.
// Holds the IF/ID pipeline register, decodes imm_sel and register fields for the
// immediate_generator, applies flush from EX and an optional load-use interlock,
// and hands the instruction to EX over a valid/ready handshake.
// Build option: define LOAD_USE_INTERLOCK_EN to enable the load-use interlock
// (hazard detection, one-cycle STALL state and the stall_count counter).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_valid/if_instr/if_pc      fetch side, handshake with id_ready
//   flush                        redirect from EX, empties ID
//   ex_ready/ex_is_load/ex_rd    EX side acceptance and load destination
//   id_valid/id_instr/id_pc      instruction presented to EX
//   imm_sel/is_upper/uses_imm    immediate_generator control
//   rs1/rs2/rd/illegal           decoded register fields, unknown-opcode flag
//   stall_count                  saturating count of interlock bubbles
module id_stage_sequencer #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  output logic                   id_ready,
  input  logic                   flush,
  input  logic                   ex_ready,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [1:0]             imm_sel,
  output logic                   is_upper,
  output logic                   uses_imm,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [4:0]             rd,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   capture;
  logic   stall_inc;
  logic   hazard;
  logic   uses_rs1;
  logic   uses_rs2;
  logic [6:0] opcode;

  // Register fields come straight from the held instruction.
  assign opcode = id_instr[6:0];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign rd     = id_instr[11:7];

  // Opcode decode for the immediate_generator and operand usage.
  always_comb begin
    imm_sel  = 2'b00;
    is_upper = 1'b0;
    uses_imm = 1'b1;
    illegal  = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_sel = 2'b00;
      7'b0100011: begin
        imm_sel  = 2'b01;
        uses_rs2 = 1'b1;
      end
      7'b1100011: begin
        imm_sel  = 2'b10;
        uses_rs2 = 1'b1;
      end
      7'b1101111: begin
        imm_sel  = 2'b11;
        uses_rs1 = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        imm_sel  = 2'b11;
        is_upper = 1'b1;
        uses_rs1 = 1'b0;
      end
      7'b0110011: begin
        uses_imm = 1'b0;
        uses_rs2 = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef LOAD_USE_INTERLOCK_EN
  // Load in EX writes a register the held instruction reads; x0 never hazards.
  assign hazard = (state_q == ST_FULL) & ex_is_load & (ex_rd != 5'd0) &
                  ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

  // Bubble counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_inc && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
`else
  logic unused_interlock;
  assign hazard           = 1'b0;
  assign stall_count      = '0;
  assign unused_interlock = ^{ex_is_load, ex_rd, stall_inc, uses_rs1, uses_rs2};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; flush outranks hazard outranks handshake.
  always_comb begin
    state_d   = state_q;
    id_valid  = 1'b0;
    id_ready  = 1'b0;
    capture   = 1'b0;
    stall_inc = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        id_ready = ~flush;
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (if_valid) begin
          capture = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        id_valid = ~hazard;
        id_ready = ~flush & ~hazard & ex_ready;
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (hazard) begin
          state_d   = ST_STALL;
          stall_inc = 1'b1;
        end else if (ex_ready) begin
          if (if_valid) begin
            capture = 1'b1;
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_STALL: begin
        state_d = flush ? ST_EMPTY : ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // IF/ID payload register; flush and reset restore the canonical NOP.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_instr <= NOP_INSTR;
      id_pc    <= 32'd0;
    end else if (capture) begin
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end
  end

endmodule

// File: tb/tb_id_stage_sequencer.sv
module tb_id_stage_sequencer;

`ifdef LOAD_USE_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, ex_ready, ex_is_load;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  ex_rd;
  logic        id_ready, id_valid, is_upper, uses_imm, illegal;
  logic [31:0] id_instr, id_pc;
  logic [1:0]  imm_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] stall_count;
  logic        s_ready, s_valid, s_upper, s_uimm, s_ill;
  logic [31:0] s_instr, s_pc;
  logic [1:0]  s_sel;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy, pending bubble, payload, bubble counts.
  bit          m_occ, m_stl;
  logic [31:0] m_instr, m_pc;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  id_stage_sequencer u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .imm_sel(imm_sel), .is_upper(is_upper), .uses_imm(uses_imm), .rs1(rs1), .rs2(rs2),
    .rd(rd), .illegal(illegal), .stall_count(stall_count)
  );

  // Narrow-counter instance to reach saturation quickly.
  id_stage_sequencer #(.STALL_CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(s_ready), .flush(flush), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .id_valid(s_valid), .id_instr(s_instr), .id_pc(s_pc),
    .imm_sel(s_sel), .is_upper(s_upper), .uses_imm(s_uimm), .rs1(s_rs1), .rs2(s_rs2),
    .rd(s_rd), .illegal(s_ill), .stall_count(s_cnt)
  );

  wire [101:0] dut_vec = {id_valid, id_ready, id_instr, id_pc, imm_sel, is_upper,
                          uses_imm, rs1, rs2, rd, illegal, stall_count};

  function automatic bit rd_rs1(logic [31:0] ins);
    return !(ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction

  function automatic bit rd_rs2(logic [31:0] ins);
    return ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit m_hazard();
    return INTERLOCK && m_occ && !m_stl && ex_is_load && (ex_rd != 5'd0) &&
           ((rd_rs1(m_instr) && m_instr[19:15] == ex_rd) ||
            (rd_rs2(m_instr) && m_instr[24:20] == ex_rd));
  endfunction

  function automatic bit m_ready();
    return !flush && (!m_occ || (!m_stl && !m_hazard() && ex_ready));
  endfunction

  function automatic logic [101:0] exp_vec();
    logic [6:0] op;
    logic [1:0] sel;
    bit up, ui, ill;
    op  = m_instr[6:0];
    sel = (op == 7'b0100011) ? 2'd1 :
          (op == 7'b1100011) ? 2'd2 :
          (op inside {7'b1101111, 7'b0110111, 7'b0010111}) ? 2'd3 : 2'd0;
    up  = op inside {7'b0110111, 7'b0010111};
    ui  = (op != 7'b0110011);
    ill = !(op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                       7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011});
    return {m_occ && !m_stl && !m_hazard(), m_ready(), m_instr, m_pc, sel, up, ui,
            m_instr[19:15], m_instr[24:20], m_instr[11:7], ill, 16'(m_cnt)};
  endfunction

  // Advance one clock and step the reference model with the held inputs.
  task automatic tick();
    bit hz, rdy;
    @(posedge clk);
    hz  = m_hazard();
    rdy = m_ready();
    if (rst) begin
      m_occ = 0; m_stl = 0; m_instr = NOP; m_pc = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (flush) begin
      m_occ = 0; m_stl = 0; m_instr = NOP; m_pc = 0;
    end else if (m_stl) begin
      m_stl = 0;
    end else if (hz) begin
      m_stl = 1;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (rdy && if_valid) begin
      m_occ = 1; m_instr = if_instr; m_pc = if_pc;
    end else if (m_occ && ex_ready) begin
      m_occ = 0;
    end
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] ins, logic [31:0] pc, bit er, bit fl,
                       bit ld, logic [4:0] erd);
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
    ex_is_load = ld; ex_rd = erd;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    tick();
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0);
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec());
    end
    total++;
    if ({id_valid, id_instr, id_pc, stall_count, imm_sel, illegal} !== {1'b0, NOP, 32'd0, 16'd0, 2'b00, 1'b0}) begin
      bad++; $display("FAIL reset_values got=%b/%h/%h/%0d exp=0/00000013/0/0", id_valid, id_instr, id_pc, stall_count);
    end
  endtask

  task automatic test_single();
    drive(1, 32'hFFF0_0093, 32'h100, 1, 0, 0, 5'd0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL single_vec got=%h exp=%h", dut_vec, exp_vec());
    end
    total++;
    if ({id_valid, imm_sel, rs1, rd, id_pc} !== {1'b1, 2'b00, 5'd0, 5'd1, 32'h100}) begin
      bad++; $display("FAIL single_fields got=%b/%b/%0d/%0d/%h exp=1/00/0/1/100", id_valid, imm_sel, rs1, rd, id_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h0011_2023, 32'h0020_8063, 32'h0000_006F, 32'h1234_5037};
    logic [1:0]  sel [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    bit          up  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1, ins[i], 32'h200 + 32'(4 * i), 1, 0, 0, 5'd0);
      else       drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL b2b_vec[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (i > 0) begin
        total++;
        if ({id_valid, id_instr, imm_sel, is_upper} !== {1'b1, ins[i-1], sel[i-1], up[i-1]}) begin
          bad++; $display("FAIL b2b_fields[%0d] got=%b/%h/%b/%b exp=1/%h/%b/%b", i, id_valid, id_instr, imm_sel, is_upper, ins[i-1], sel[i-1], up[i-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [31:0] held_i, held_p;
    held_i = id_instr; held_p = id_pc;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0000_0513, 32'h300, 0, 0, 0, 5'd0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL hold_vec[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
      total++;
      if ({id_ready, id_valid, id_instr, id_pc} !== {1'b0, 1'b1, held_i, held_p}) begin
        bad++; $display("FAIL hold_stable[%0d] got=%b/%b/%h/%h exp=0/1/%h/%h", i, id_ready, id_valid, id_instr, id_pc, held_i, held_p);
      end
      tick();
    end
    drive(1, 32'h0000_0513, 32'h300, 1, 0, 0, 5'd0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    total++;
    if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h0000_0513, 32'h300}) begin
      bad++; $display("FAIL hold_release got=%b/%h/%h exp=1/00000513/300", id_valid, id_instr, id_pc);
    end
  endtask

  task automatic test_interlock();
    int base;
    drive(1, 32'h0020_8063, 32'h400, 1, 0, 0, 5'd0);
    tick();
    base = m_cnt;
    // Hazard cycle, then the bubble cycle, then the instruction is offered again.
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 32'h0, 0, 0, i == 0, 5'd2);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL interlock_vec[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    total++;
    if ({id_valid, id_instr, stall_count} !== {1'b1, 32'h0020_8063, 16'(base + int'(INTERLOCK))}) begin
      bad++; $display("FAIL interlock_after got=%b/%h/%0d exp=1/00208063/%0d", id_valid, id_instr, stall_count, base + int'(INTERLOCK));
    end
    drive(0, 32'h0, 32'h0, 0, 0, 1, 5'd0);
    total++;
    if (id_valid !== 1'b1) begin
      bad++; $display("FAIL interlock_x0 got=%b exp=1", id_valid);
    end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 32'h0, 0, 0, 1, 5'd1);
      tick();
      drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      tick();
      total++;
      if (s_cnt !== 2'(m_cnt2)) begin
        bad++; $display("FAIL saturate[%0d] got=%0d exp=%0d", i, s_cnt, m_cnt2);
      end
    end
    total++;
    if (s_cnt !== (INTERLOCK ? 2'd3 : 2'd0)) begin
      bad++; $display("FAIL saturate_final got=%0d exp=%0d", s_cnt, INTERLOCK ? 3 : 0);
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h0000_0593, 32'h500, 1, 1, 0, 5'd0);
    total++;
    if (id_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b exp=0", id_ready);
    end
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    total++;
    if ({id_valid, id_instr} !== {1'b0, NOP}) begin
      bad++; $display("FAIL flush_after got=%b/%h exp=0/00000013", id_valid, id_instr);
    end
  endtask

  task automatic test_illegal();
    drive(1, 32'hFE00_00FF, 32'h600, 1, 0, 0, 5'd0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    total++;
    if ({illegal, id_valid} !== 2'b11) begin
      bad++; $display("FAIL illegal got=%b/%b exp=1/1", illegal, id_valid);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [11] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                             7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011,
                             7'b1111111};
    logic [31:0] ins;
    for (int i = 0; i < 600; i++) begin
      ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
      rst = ($urandom_range(0, 60) == 0);
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 12) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
      if (!rst) begin
        total++;
        if (dut_vec !== exp_vec() || s_cnt !== 2'(m_cnt2)) begin
          bad++; $display("FAIL random[%0d] got=%h/%0d exp=%h/%0d", i, dut_vec, s_cnt, exp_vec(), m_cnt2);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_occ = 0; m_stl = 0; m_instr = NOP; m_pc = 0; m_cnt = 0; m_cnt2 = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_interlock();
    test_saturate();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
